// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 UART transmitter with free-running oversample baud tick; ports clk, reset (async), start/tx_input in, tx_out/tx_status/baud_tick out
module uart_tx_unit #(
  parameter int CLOCK_HZ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_input,
  output logic                  tx_out,
  output logic                  tx_status,
  output logic                  baud_tick
);
  localparam int DIV = CLOCK_HZ / (OVERSAMPLE * BAUD);
  localparam int CW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
  if (DIV < 1 || OVERSAMPLE < 2 || FRAME_BITS < 1) begin : g_param_err
    $error("uart_tx_unit: DIV >= 1, OVERSAMPLE >= 2, FRAME_BITS >= 1 required");
  end
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                state, state_n;
  logic [CW-1:0]         cnt;
  logic [SW-1:0]         samp, samp_n;
  logic [BW-1:0]         bit_idx, bit_n;
  logic [FRAME_BITS-1:0] data, data_n;
  logic                  adv, last, tx_n;
  assign baud_tick = cnt == CW'(DIV - 1);
  assign adv       = baud_tick && samp == SW'(OVERSAMPLE - 1);
  assign last      = bit_idx == BW'(FRAME_BITS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= baud_tick ? '0 : cnt + CW'(1);
  always_comb begin
    state_n = state;
    samp_n  = samp;
    bit_n   = bit_idx;
    data_n  = data;
    case (state)
      IDLE: if (start) begin
        state_n = START;
        data_n  = tx_input;
        samp_n  = '0;
        bit_n   = '0;
      end
      START: state_n = adv ? DATA : START;
      DATA: if (adv) begin
        state_n = last ? STOP : DATA;
        bit_n   = last ? '0 : bit_idx + BW'(1);
        data_n  = data >> 1;
      end
      default: state_n = adv ? IDLE : STOP;
    endcase
    if (state != IDLE && baud_tick) samp_n = adv ? '0 : samp + SW'(1);
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? data_n[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      samp      <= '0;
      bit_idx   <= '0;
      data      <= '0;
      tx_out    <= 1'b1;
      tx_status <= 1'b0;
    end else begin
      state     <= state_n;
      samp      <= samp_n;
      bit_idx   <= bit_n;
      data      <= data_n;
      tx_out    <= tx_n;
      tx_status <= state_n != IDLE;
    end
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed self-checking bench for uart_tx_unit at default parameters
module tb_uart_tx_unit;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] tx_input = '0;
  logic       tx_out, tx_status, baud_tick;
  int         errors = 0, checks = 0;
  uart_tx_unit dut (
    .clk(clk), .reset(reset), .start(start), .tx_input(tx_input),
    .tx_out(tx_out), .tx_status(tx_status), .baud_tick(baud_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    tx_input = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept", {tx_out, tx_status}, 2'b01);
  endtask
  task automatic recv(input logic [7:0] exp, input int mode);
    logic [9:0] bits = '0;
    logic       st = 1'b0;
    int         ticks = 0, cyc = 0;
    while (tx_status && cyc < 9000) begin
      if (baud_tick) begin
        ticks++;
        if (ticks >= 8 && ticks <= 152 && (ticks - 8) % 16 == 0) bits[(ticks - 8) / 16] = tx_out;
        if (ticks == 152) st = tx_status;
        if (mode == 2 && ticks == 72) begin
          chk("bit3_low", tx_out, 1'b0);
          reset = 1'b1;
          #1;
          chk("abort", {tx_out, tx_status}, 2'b10);
          return;
        end
      end
      start = mode == 1 && ticks == 60 && baud_tick;
      if (start) tx_input = 8'hFF;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 9000) chk("frame_timeout", cyc, 0);
    chk("start_bit", bits[0], 1'b0);
    chk("data", bits[8:1], exp);
    chk("stop_bit", bits[9], 1'b1);
    chk("busy_in_frame", st, 1'b1);
    chk("frame_len_ok", cyc >= 159 * 54 + 1 && cyc <= 160 * 54, 1'b1);
  endtask
  initial begin
    int n, bad;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_state", {tx_out, tx_status, baud_tick}, 3'b100);
    end
    reset = 1'b0;
    n = 0;
    while (!baud_tick && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("first_tick_seen", baud_tick, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      bad = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) chk("tick_width", baud_tick, 1'b0);
        if (tx_out !== 1'b1 || tx_status !== 1'b0) bad++;
      end while (!baud_tick && n < 200);
      chk("tick_period", n, 54);
      chk("idle_line", bad, 0);
    end
    send(8'h55);
    recv(8'h55, 0);
    send(8'h3C);
    recv(8'h3C, 0);
    repeat (100) @(negedge clk);
    send(8'hA5);
    recv(8'hA5, 0);
    repeat (20) @(negedge clk);
    chk("idle_after_a5", {tx_out, tx_status}, 2'b10);
    send(8'h55);
    recv(8'h55, 1);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_status !== 1'b0) bad++;
    end
    chk("no_second_frame", bad, 0);
    send(8'h55);
    recv(8'h55, 2);
    repeat (3) begin
      @(negedge clk);
      chk("held_reset", {tx_out, tx_status}, 2'b10);
    end
    reset = 1'b0;
    @(negedge clk);
    send(8'h81);
    recv(8'h81, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
